udma_mram_erase_seq: RTL and testbench
======================================

# udma_mram_erase_seq

Erase sequencer that sits directly downstream of the uDMA MRAM register interface. It consumes the erase start address, line count and trigger programmed by software, and issues one erase command per MRAM line to the macro controller over a req/ack handshake. It returns the `erase_pending` status bit and the erase `event_done` pulse that feed the register interface's status and IRQ logic. A per-command ack timeout and an abort input guarantee the sequencer always returns to idle.

## Interface
- ADDR_W, 16, MRAM line address width (matches `mram_erase_addr_o`)
- SIZE_W, 10, line-count width (matches `mram_erase_size_o`)
- GAP, 2, idle cycles between an ack and the next request; legal range 1..15
- TIMEOUT, 1024, maximum cycles `mram_req_o` may stay high without ack; must be ≥ 2
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- erase_start_i  in  1  single-cycle start pulse
- erase_addr_i  in  ADDR_W  first line address, sampled on start
- erase_size_i  in  SIZE_W  number of lines to erase, sampled on start; 0 means no lines
- abort_i  in  1  level; terminates the sequence
- mram_req_o  out  1  erase command request to the macro controller
- mram_addr_o  out  ADDR_W  line address of the current command
- mram_ack_i  in  1  single-cycle command acceptance
- erase_pending_o  out  1  sequence in progress
- event_done_o  out  1  single-cycle completion pulse (normal, abort or timeout)
- erase_err_o  out  1  sticky timeout flag; cleared on the next accepted start
- lines_done_o  out  SIZE_W  number of acked commands in the current or last sequence

## Operation
- The state machine has four states: IDLE, REQ, GAP, DONE.
- IDLE:
  - An `erase_start_i` pulse latches the address into `mram_addr_o` and the size into the remaining count.
  - The same pulse clears `lines_done_o` and `erase_err_o` and resets the timeout counter.
  - Next state is REQ if size ≠ 0, otherwise DONE.
- REQ:
  - `mram_req_o` = 1 and `mram_addr_o` is held stable.
  - On `mram_ack_i`: `lines_done_o`++, remaining count--, address++ (modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000).
  - After the ack, next state is DONE if the remaining count reaches 0, otherwise GAP.
- GAP:
  - `mram_req_o` = 0 for exactly GAP cycles, counted by a 4-bit counter.
  - Then the timeout counter is reset and the state returns to REQ.
- Timeout:
  - In REQ, the timeout counter increments every cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, `erase_err_o` is set and the state goes to DONE.
  - The ack that increments nothing is not counted.
- Abort:
  - `abort_i` high in REQ or GAP forces DONE.
  - An ack in the same cycle as the abort is counted; the address and count still update.
  - `abort_i` in IDLE or DONE is ignored.
  - `erase_err_o` is not set by an abort.
- DONE: `event_done_o` = 1 for one cycle, then the state returns to IDLE unconditionally.
- `erase_start_i` outside IDLE is ignored: no re-latching and no pulse queued.
- Simultaneous ack and timeout-expiry cycle: the ack wins and no error is raised.
- `erase_pending_o` = 1 in REQ, GAP and DONE, and 0 in IDLE.

## Timing
- Reset values:
  - State is IDLE.
  - `mram_req_o`, `erase_pending_o`, `event_done_o`, `erase_err_o` are 0.
  - `mram_addr_o` = 0 and `lines_done_o` = 0.
- Reset asserted mid-sequence drops `mram_req_o` immediately (asynchronously) with no `event_done_o`.
- All outputs are registered; no combinational path from any input to any output.
- Start sampled at edge N: `erase_pending_o` and `mram_req_o` rise in cycle N+1.
- Ack sampled at edge K:
  - `mram_req_o` is 0 in cycles K+1..K+GAP.
  - `mram_req_o` returns to 1 with the new address in cycle K+GAP+1.
- Last ack at edge K: `event_done_o` = 1 in cycle K+1, and `erase_pending_o` falls in cycle K+2.
- Size = 0: `event_done_o` in cycle N+1 and no request is issued.
- Handshake rule: `mram_req_o` never drops without an ack except on abort or timeout, and the address never changes while `mram_req_o` = 1.
- Total duration for S lines with ack latency L each: S·L + (S−1)·GAP + 1 cycles from start to the done pulse.

## Test plan
- Nominal run, addr=0x0010, size=3, ack 2 cycles after each req, GAP=2:
  - Requests are issued to 0x0010, 0x0011, 0x0012.
  - `lines_done_o`=3 and `event_done_o` pulses exactly once.
  - No req in the GAP cycles.
- Wrap-around, addr=0xFFFE, size=3:
  - Commands are issued to 0xFFFE, 0xFFFF, 0x0000.
  - Final `mram_addr_o`=0x0001.
- Size=0 start:
  - No `mram_req_o`.
  - `event_done_o` is high in the cycle after start.
  - `lines_done_o`=0.
- Timeout with TIMEOUT=16 and ack never asserted:
  - `mram_req_o` stays high for 16 cycles and then drops.
  - `erase_err_o`=1 and `event_done_o` pulses.
  - The next start clears `erase_err_o`.
- Abort, size=5, `abort_i` asserted in the same cycle as the 2nd ack:
  - `lines_done_o`=2 and no 3rd req is issued.
  - `event_done_o` pulses and `erase_err_o`=0.
- Start while busy, plus reset mid-REQ:
  - A second start during REQ is ignored (address is unchanged).
  - Pulling `rstn_i` low mid-REQ clears `mram_req_o` and `erase_pending_o` immediately, with no done pulse.

Source files
------------

// File: rtl/udma_mram_erase_seq_if.sv
// Erase command handshake between the erase sequencer (master) and the
// MRAM macro controller (slave).
interface udma_mram_erase_seq_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              mram_req;
  logic [ADDR_W-1:0] mram_addr;
  logic              mram_ack;

  modport master (
    output mram_req,
    output mram_addr,
    input  mram_ack
  );

  modport slave (
    input  mram_req,
    input  mram_addr,
    output mram_ack
  );
endinterface

// File: rtl/udma_mram_erase_seq.sv
// MRAM erase sequencer: issues one erase command per line over a req/ack
// handshake, with inter-command gap, per-command ack timeout and abort.
module udma_mram_erase_seq #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned SIZE_W  = 10,
  parameter int unsigned GAP     = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  erase_start_i,
  input  logic [ADDR_W-1:0]     erase_addr_i,
  input  logic [SIZE_W-1:0]     erase_size_i,
  input  logic                  abort_i,
  udma_mram_erase_seq_if.master mram,
  output logic                  erase_pending_o,
  output logic                  event_done_o,
  output logic                  erase_err_o,
  output logic [SIZE_W-1:0]     lines_done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [SIZE_W-1:0] rem_q,   rem_d;
  logic [SIZE_W-1:0] lines_q, lines_d;
  logic [TW-1:0]     tmo_q,   tmo_d;
  logic [3:0]        gap_q,   gap_d;
  logic              req_q,   req_d;
  logic              pend_q,  pend_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;

  // Outputs are driven from next-state values registered alongside the
  // state, so every output is a flop with no input-to-output path.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lines_d = lines_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    req_d   = req_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (erase_start_i) begin
          addr_d  = erase_addr_i;
          rem_d   = erase_size_i;
          lines_d = '0;
          err_d   = 1'b0;
          tmo_d   = '0;
          pend_d  = 1'b1;
          if (erase_size_i != '0) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_REQ: begin
        // Ack has priority over both abort and timeout expiry.
        if (mram.mram_ack) begin
          lines_d = lines_q + SIZE_W'(1);
          rem_d   = rem_q - SIZE_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          gap_d   = '0;
          req_d   = 1'b0;
          if (rem_q == SIZE_W'(1) || abort_i) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end else if (abort_i) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_DONE;
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      ST_GAP: begin
        if (abort_i) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lines_q <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lines_q <= lines_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mram.mram_req   = req_q;
  assign mram.mram_addr  = addr_q;
  assign erase_pending_o = pend_q;
  assign event_done_o    = done_q;
  assign erase_err_o     = err_q;
  assign lines_done_o    = lines_q;

endmodule

// File: tb/tb_udma_mram_erase_seq.sv
// Randomized bench for udma_mram_erase_seq with a transaction-level model
// of expected commands, line count, error flag and completion time.
module tb_udma_mram_erase_seq;

  localparam int unsigned GAP = 2;
  localparam int unsigned TMO = 16;
  localparam int BOUND = 400;

  logic        clk = 1'b0;
  logic        rstn;
  logic        erase_start;
  logic [15:0] erase_addr;
  logic [9:0]  erase_size;
  logic        abort;
  logic        pending, done, err;
  logic [9:0]  lines;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  udma_mram_erase_seq_if #(.ADDR_W(16)) bus ();

  udma_mram_erase_seq #(
    .ADDR_W (16),
    .SIZE_W (10),
    .GAP    (GAP),
    .TIMEOUT(TMO)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn),
    .erase_start_i  (erase_start),
    .erase_addr_i   (erase_addr),
    .erase_size_i   (erase_size),
    .abort_i        (abort),
    .mram           (bus.master),
    .erase_pending_o(pending),
    .event_done_o   (done),
    .erase_err_o    (err),
    .lines_done_o   (lines)
  );

  // Per-command ack latency in cycles of req high; 0 = never acknowledge.
  int unsigned lat[8];

  logic [15:0] obs_addrs[$];
  logic [15:0] exp_addrs[$];
  int obs_done_cnt, obs_done_cyc, obs_gap_bad, obs_hs_bad, obs_pend_bad, obs_hi_max;
  logic obs_pend_fall, obs_err;
  logic [9:0]  obs_lines;
  logic [15:0] obs_final_addr;
  int exp_lines, exp_cyc;
  logic exp_err;

  // Reference: walk the commands, accumulating cycles from the start pulse.
  function automatic void model(input logic [15:0] a, input int s, input int abort_idx);
    int c = 1;
    exp_addrs.delete();
    exp_lines = 0;
    exp_err   = 1'b0;
    for (int i = 0; i < s; i++) begin
      exp_addrs.push_back(16'(a + i));
      if (lat[i] == 0) begin
        c += TMO;
        exp_err = 1'b1;
        break;
      end
      c += int'(lat[i]);
      exp_lines++;
      if (i == abort_idx || i == s - 1) break;
      c += GAP;
    end
    exp_cyc = c;
  endfunction

  // Drives one sequence, acts as the macro controller and records what it sees.
  task automatic run_seq(input logic [15:0] a, input logic [9:0] s, input int abort_idx);
    int   cyc = 0, idx = 0, hi = 0, low_cnt = 0;
    logic prev_req = 1'b0, gap_active = 1'b0, r;
    logic [15:0] prev_addr = '0;
    obs_addrs.delete();
    obs_done_cnt = 0; obs_done_cyc = -1; obs_gap_bad = 0; obs_hs_bad = 0;
    obs_pend_bad = 0; obs_hi_max = 0; obs_pend_fall = 1'b0;
    @(negedge clk);
    erase_start = 1'b1; erase_addr = a; erase_size = s;
    while (cyc < BOUND) begin
      @(negedge clk);
      cyc++;
      erase_start = 1'b0; bus.mram_ack = 1'b0; abort = 1'b0;
      r = bus.mram_req;
      if (r && !prev_req) begin
        obs_addrs.push_back(bus.mram_addr);
        hi = 0;
        if (gap_active && low_cnt != GAP) obs_gap_bad++;
        gap_active = 1'b0;
      end
      if (r && prev_req && bus.mram_addr != prev_addr) obs_hs_bad++;
      if (!r && gap_active) low_cnt++;
      if (r) begin
        hi++;
        if (hi > obs_hi_max) obs_hi_max = hi;
        if (idx < 8 && lat[idx] != 0 && hi == int'(lat[idx])) begin
          bus.mram_ack = 1'b1;
          if (idx == abort_idx) abort = 1'b1;
          idx++;
          gap_active = 1'b1;
          low_cnt = 0;
        end
      end
      if (obs_done_cyc < 0 && !pending) obs_pend_bad++;
      if (done) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) obs_done_cyc = cyc;
      end
      if (obs_done_cyc >= 0 && cyc == obs_done_cyc + 1) obs_pend_fall = !pending;
      prev_req  = r;
      prev_addr = bus.mram_addr;
      if (obs_done_cyc >= 0 && cyc == obs_done_cyc + 4) break;
    end
    obs_lines      = lines;
    obs_err        = err;
    obs_final_addr = bus.mram_addr;
  endtask

  task automatic test_reset;
    n_vec++;
    if ({bus.mram_req, pending, done, err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags req/pend/done/err=%b required 0000",
                        {bus.mram_req, pending, done, err});
    end
    n_vec++;
    if (bus.mram_addr !== 16'h0000 || lines !== 10'd0) begin
      n_err++; $display("FAIL reset_vals addr=%h lines=%0d required 0/0", bus.mram_addr, lines);
    end
    @(negedge clk); abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if (pending !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL idle_abort pend=%b done=%b required 0/0", pending, done);
    end
  endtask

  task automatic test_nominal;
    for (int i = 0; i < 8; i++) lat[i] = 2;
    model(16'h0010, 3, -1);
    run_seq(16'h0010, 10'd3, -1);
    n_vec++;
    if (obs_addrs.size() != exp_addrs.size()) begin
      n_err++; $display("FAIL nom_cmds got %0d required %0d", obs_addrs.size(), exp_addrs.size());
    end
    for (int i = 0; i < obs_addrs.size() && i < exp_addrs.size(); i++) begin
      n_vec++;
      if (obs_addrs[i] !== exp_addrs[i]) begin
        n_err++; $display("FAIL nom_addr%0d got %h required %h", i, obs_addrs[i], exp_addrs[i]);
      end
    end
    n_vec++;
    if (obs_lines !== 10'(exp_lines)) begin
      n_err++; $display("FAIL nom_lines got %0d required %0d", obs_lines, exp_lines);
    end
    n_vec++;
    if (obs_done_cnt != 1 || obs_done_cyc != exp_cyc) begin
      n_err++; $display("FAIL nom_done cnt=%0d cyc=%0d required 1/%0d", obs_done_cnt, obs_done_cyc, exp_cyc);
    end
    n_vec++;
    if (obs_gap_bad != 0 || obs_hs_bad != 0) begin
      n_err++; $display("FAIL nom_gap gap_bad=%0d hs_bad=%0d required 0/0", obs_gap_bad, obs_hs_bad);
    end
    n_vec++;
    if (obs_pend_bad != 0 || obs_pend_fall !== 1'b1) begin
      n_err++; $display("FAIL nom_pending bad=%0d fall=%b required 0/1", obs_pend_bad, obs_pend_fall);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 8; i++) lat[i] = 1;
    model(16'hFFFE, 3, -1);
    run_seq(16'hFFFE, 10'd3, -1);
    n_vec++;
    if (obs_addrs.size() != 3) begin
      n_err++; $display("FAIL wrap_cmds got %0d required 3", obs_addrs.size());
    end
    for (int i = 0; i < obs_addrs.size() && i < exp_addrs.size(); i++) begin
      n_vec++;
      if (obs_addrs[i] !== exp_addrs[i]) begin
        n_err++; $display("FAIL wrap_addr%0d got %h required %h", i, obs_addrs[i], exp_addrs[i]);
      end
    end
    n_vec++;
    if (obs_final_addr !== 16'(16'hFFFE + exp_lines)) begin
      n_err++; $display("FAIL wrap_final got %h required %h", obs_final_addr, 16'(16'hFFFE + exp_lines));
    end
  endtask

  task automatic test_size_zero;
    model(16'h0ABC, 0, -1);
    run_seq(16'h0ABC, 10'd0, -1);
    n_vec++;
    if (obs_addrs.size() != 0) begin
      n_err++; $display("FAIL zero_req got %0d cmds required 0", obs_addrs.size());
    end
    n_vec++;
    if (obs_done_cnt != 1 || obs_done_cyc != exp_cyc) begin
      n_err++; $display("FAIL zero_done cnt=%0d cyc=%0d required 1/%0d", obs_done_cnt, obs_done_cyc, exp_cyc);
    end
    n_vec++;
    if (obs_lines !== 10'd0) begin
      n_err++; $display("FAIL zero_lines got %0d required 0", obs_lines);
    end
  endtask

  task automatic test_timeout;
    for (int i = 0; i < 8; i++) lat[i] = 0;
    model(16'h0200, 3, -1);
    run_seq(16'h0200, 10'd3, -1);
    n_vec++;
    if (obs_addrs.size() != 1 || obs_hi_max != int'(TMO)) begin
      n_err++; $display("FAIL tmo_req cmds=%0d high=%0d required 1/%0d", obs_addrs.size(), obs_hi_max, TMO);
    end
    n_vec++;
    if (obs_err !== exp_err || obs_lines !== 10'(exp_lines)) begin
      n_err++; $display("FAIL tmo_err err=%b lines=%0d required %b/%0d", obs_err, obs_lines, exp_err, exp_lines);
    end
    n_vec++;
    if (obs_done_cnt != 1 || obs_done_cyc != exp_cyc) begin
      n_err++; $display("FAIL tmo_done cnt=%0d cyc=%0d required 1/%0d", obs_done_cnt, obs_done_cyc, exp_cyc);
    end
    @(negedge clk); erase_start = 1'b1; erase_size = 10'd0;
    @(negedge clk); erase_start = 1'b0;
    n_vec++;
    if (err !== 1'b0) begin
      n_err++; $display("FAIL tmo_clear err=%b required 0", err);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort;
    for (int i = 0; i < 8; i++) lat[i] = 2;
    model(16'h0300, 5, 1);
    run_seq(16'h0300, 10'd5, 1);
    n_vec++;
    if (obs_addrs.size() != exp_addrs.size() || obs_lines !== 10'(exp_lines)) begin
      n_err++; $display("FAIL abort_lines cmds=%0d lines=%0d required %0d/%0d",
                        obs_addrs.size(), obs_lines, exp_addrs.size(), exp_lines);
    end
    n_vec++;
    if (obs_done_cnt != 1 || obs_done_cyc != exp_cyc || obs_err !== 1'b0) begin
      n_err++; $display("FAIL abort_done cnt=%0d cyc=%0d err=%b required 1/%0d/0",
                        obs_done_cnt, obs_done_cyc, obs_err, exp_cyc);
    end
  endtask

  task automatic test_random;
    logic [15:0] a;
    int s, ab;
    for (int it = 0; it < 10; it++) begin
      a = 16'($urandom);
      s = int'($urandom_range(1, 6));
      for (int i = 0; i < 8; i++) lat[i] = $urandom_range(1, 4);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, s - 1)) : -1;
      model(a, s, ab);
      run_seq(a, 10'(s), ab);
      n_vec++;
      if (obs_addrs.size() != exp_addrs.size()) begin
        n_err++; $display("FAIL rnd%0d_cmds got %0d required %0d", it, obs_addrs.size(), exp_addrs.size());
      end
      for (int i = 0; i < obs_addrs.size() && i < exp_addrs.size(); i++) begin
        n_vec++;
        if (obs_addrs[i] !== exp_addrs[i]) begin
          n_err++; $display("FAIL rnd%0d_addr%0d got %h required %h", it, i, obs_addrs[i], exp_addrs[i]);
        end
      end
      n_vec++;
      if (obs_lines !== 10'(exp_lines) || obs_err !== exp_err) begin
        n_err++; $display("FAIL rnd%0d_status lines=%0d err=%b required %0d/%b",
                          it, obs_lines, obs_err, exp_lines, exp_err);
      end
      n_vec++;
      if (obs_done_cnt != 1 || obs_done_cyc != exp_cyc) begin
        n_err++; $display("FAIL rnd%0d_done cnt=%0d cyc=%0d required 1/%0d", it, obs_done_cnt, obs_done_cyc, exp_cyc);
      end
      n_vec++;
      if (obs_gap_bad != 0 || obs_hs_bad != 0 || obs_pend_bad != 0 || obs_pend_fall !== 1'b1) begin
        n_err++; $display("FAIL rnd%0d_proto gap=%0d hs=%0d pend=%0d fall=%b required 0/0/0/1",
                          it, obs_gap_bad, obs_hs_bad, obs_pend_bad, obs_pend_fall);
      end
      n_vec++;
      if (obs_final_addr !== 16'(a + exp_lines)) begin
        n_err++; $display("FAIL rnd%0d_final got %h required %h", it, obs_final_addr, 16'(a + exp_lines));
      end
    end
  endtask

  task automatic test_busy_reset;
    int dones = 0;
    @(negedge clk); erase_start = 1'b1; erase_addr = 16'h1234; erase_size = 10'd4;
    @(negedge clk); erase_start = 1'b0;
    repeat (2) @(negedge clk);
    erase_start = 1'b1; erase_addr = 16'h5555; erase_size = 10'd1;
    @(negedge clk); erase_start = 1'b0;
    n_vec++;
    if (bus.mram_addr !== 16'h1234 || bus.mram_req !== 1'b1) begin
      n_err++; $display("FAIL busy_start addr=%h req=%b required 1234/1", bus.mram_addr, bus.mram_req);
    end
    #2 rstn = 1'b0;
    #1;
    n_vec++;
    if (bus.mram_req !== 1'b0 || pending !== 1'b0) begin
      n_err++; $display("FAIL async_rst req=%b pend=%b required 0/0", bus.mram_req, pending);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_vec++;
    if (dones != 0 || lines !== 10'd0 || bus.mram_addr !== 16'h0000) begin
      n_err++; $display("FAIL rst_nodone dones=%0d lines=%0d addr=%h required 0/0/0000",
                        dones, lines, bus.mram_addr);
    end
  endtask

  initial begin
    rstn = 1'b0; erase_start = 1'b0; erase_addr = '0; erase_size = '0;
    abort = 1'b0; bus.mram_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    test_reset;
    rstn = 1'b1;
    test_reset;
    test_nominal;
    test_wrap;
    test_size_zero;
    test_timeout;
    test_abort;
    test_random;
    test_busy_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
